// File: rtl/sobel_edge.sv
// ---------------------------------------------------------------------------
// sobel_edge
//   Converts an RGB888 pixel stream to 8-bit luma, builds a 3x3 window from
//   two line buffers and emits the saturated Sobel gradient magnitude
//   |Gx| + |Gy| for every accepted input pixel.
//
//   Four register stages (luma, window, gradient, magnitude), so a pixel
//   presented in cycle k produces its result in cycle k+4. There is no
//   backpressure, and gaps in pix_valid_i pass through unchanged.
//   The result for input (r, c) is centred on (r-1, c-1). Results with r<2 or
//   c<2 are forced to 0 but are still emitted, so each frame yields exactly
//   IMG_WIDTH*IMG_HEIGHT results.
//
//   Optional feature (macro SOBEL_BINARY_EN): when defined, the output is
//   8'hFF if the magnitude exceeds THRESHOLD and 8'h00 otherwise. Border
//   results stay 0.
//
// Ports:
//   sys_clk_i      in   1  clock, rising edge
//   sys_rst_i      in   1  synchronous reset, active-low
//   frame_start_i  in   1  pulse before first pixel; clears row/col counters
//   pix_valid_i    in   1  input pixel strobe
//   red_i          in   8  red component
//   green_i        in   8  green component
//   blue_i         in   8  blue component
//   edge_o         out  8  gradient magnitude (or binary edge)
//   edge_valid_o   out  1  edge_o valid strobe
//   frame_done_o   out  1  pulse with the last result of a frame
// ---------------------------------------------------------------------------
module sobel_edge #(
    parameter int         IMG_WIDTH  = 640,
    parameter int         IMG_HEIGHT = 480,
    parameter logic [7:0] THRESHOLD  = 8'd64
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       frame_start_i,
    input  logic       pix_valid_i,
    input  logic [7:0] red_i,
    input  logic [7:0] green_i,
    input  logic [7:0] blue_i,
    output logic [7:0] edge_o,
    output logic       edge_valid_o,
    output logic       frame_done_o
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    // Geometry counters; active drops after the last pixel of a frame
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             active;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic             cur_active;
    logic             accept;

    // Line buffers: lb1 holds row-1, lb0 holds row-2
    logic [7:0] lb0 [IMG_WIDTH];
    logic [7:0] lb1 [IMG_WIDTH];

    // Stage 1: luma
    logic             s1_valid;
    logic [7:0]       s1_luma;
    logic [COL_W-1:0] s1_col;
    logic             s1_border;
    logic             s1_last;
    logic [15:0]      luma_sum;

    // Stage 2: window, indexed [row][col]; row 0 is the oldest line, col 2 the newest column
    logic       s2_valid;
    logic [7:0] win [3][3];
    logic       s2_border;
    logic       s2_last;

    // Stage 3: gradients
    logic              s3_valid;
    logic signed [10:0] gx;
    logic signed [10:0] gy;
    logic              s3_border;
    logic              s3_last;
    logic [9:0]        gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [10:0] gx_next, gy_next;

    // Stage 4: magnitude
    logic [10:0] abs_gx, abs_gy;
    logic [11:0] mag;
    logic [7:0]  edge_next;

    // A frame_start pulse takes effect before a pixel arriving in the same cycle
    always_comb begin
        if (frame_start_i) begin
            cur_col    = '0;
            cur_row    = '0;
            cur_active = 1'b1;
        end else begin
            cur_col    = col;
            cur_row    = row;
            cur_active = active;
        end
    end

    assign accept = pix_valid_i && cur_active;

    // Row/column counters and frame-active flag
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            col    <= '0;
            row    <= '0;
            active <= 1'b0;
        end else if (accept) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                if (cur_row == ROW_LAST) begin
                    row    <= '0;
                    active <= 1'b0;
                end else begin
                    row    <= cur_row + 1'b1;
                    active <= cur_active;
                end
            end else begin
                col    <= cur_col + 1'b1;
                row    <= cur_row;
                active <= cur_active;
            end
        end else begin
            col    <= cur_col;
            row    <= cur_row;
            active <= cur_active;
        end
    end

    // Luma weights sum to 256, so the shifted result always fits 8 bits
    assign luma_sum = 16'd77 * {8'd0, red_i} + 16'd150 * {8'd0, green_i} + 16'd29 * {8'd0, blue_i};

    // Stage 1 valid
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
        end
    end

    // Stage 1 data: luma plus position tags that travel with the pixel
    always_ff @(posedge sys_clk_i) begin
        if (accept) begin
            s1_luma   <= 8'(luma_sum >> 8);
            s1_col    <= cur_col;
            s1_border <= (cur_row < ROW_W'(2)) || (cur_col < COL_W'(2));
            s1_last   <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end
    end

    // Line buffers are never cleared; border masking hides stale contents
    always_ff @(posedge sys_clk_i) begin
        if (s1_valid) begin
            lb1[s1_col] <= s1_luma;
            lb0[s1_col] <= lb1[s1_col];
        end
    end

    // Stage 2 valid
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
    end

    // Stage 2 data: shift window left and load new column {row-2, row-1, row}
    always_ff @(posedge sys_clk_i) begin
        if (s1_valid) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb0[s1_col];
            win[1][2] <= lb1[s1_col];
            win[2][2] <= s1_luma;
            s2_border <= s1_border;
            s2_last   <= s1_last;
        end
    end

    // Sobel kernels; each side sums to at most 1020 so 11-bit signed never overflows
    always_comb begin
        gx_pos  = {2'b00, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b00, win[2][2]};
        gx_neg  = {2'b00, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b00, win[2][0]};
        gy_pos  = {2'b00, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b00, win[2][2]};
        gy_neg  = {2'b00, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b00, win[0][2]};
        gx_next = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
        gy_next = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    end

    // Stage 3 valid
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            s3_valid <= 1'b0;
        end else begin
            s3_valid <= s2_valid;
        end
    end

    // Stage 3 data: registered gradients
    always_ff @(posedge sys_clk_i) begin
        if (s2_valid) begin
            gx        <= gx_next;
            gy        <= gy_next;
            s3_border <= s2_border;
            s3_last   <= s2_last;
        end
    end

    // Magnitude and output mapping
    always_comb begin
        abs_gx = gx[10] ? 11'(-gx) : gx;
        abs_gy = gy[10] ? 11'(-gy) : gy;
        mag    = {1'b0, abs_gx} + {1'b0, abs_gy};
`ifdef SOBEL_BINARY_EN
        edge_next = (mag > {4'd0, THRESHOLD}) ? 8'hFF : 8'h00;
`else
        edge_next = (mag > 12'd255) ? 8'hFF : mag[7:0];
`endif
    end

`ifndef SOBEL_BINARY_EN
    // THRESHOLD only matters for the binary output
    logic [7:0] unused_threshold;
    assign unused_threshold = THRESHOLD;
`endif

    // Stage 4: registered outputs; frame_done rides with the last pixel's result
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            edge_o       <= 8'd0;
            edge_valid_o <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            edge_o       <= (s3_valid && !s3_border) ? edge_next : 8'd0;
            edge_valid_o <= s3_valid;
            frame_done_o <= s3_valid && s3_last;
        end
    end

endmodule
